// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcode map, unit indices,
// FSM states and compare result codes.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_MUL   = 4'b0010;
    localparam logic [3:0] ALU_DIV   = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_NAND  = 4'b0110;
    localparam logic [3:0] ALU_NOR   = 4'b0111;
    localparam logic [3:0] ALU_NOP   = 4'b1000;
    localparam logic [3:0] ALU_EQ    = 4'b1001;
    localparam logic [3:0] ALU_GT    = 4'b1010;
    localparam logic [3:0] ALU_LT    = 4'b1011;
    localparam logic [3:0] ALU_SHR_A = 4'b1100;
    localparam logic [3:0] ALU_SHL_A = 4'b1101;
    localparam logic [3:0] ALU_SHR_B = 4'b1110;
    localparam logic [3:0] ALU_SHL_B = 4'b1111;

    localparam int UNIT_ARITH = 0;
    localparam int UNIT_LOGIC = 1;
    localparam int UNIT_CMP   = 2;
    localparam int UNIT_SHIFT = 3;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } alu_state_t;

    localparam logic [1:0] CMP_NONE = 2'd0;
    localparam logic [1:0] CMP_EQ   = 2'd1;
    localparam logic [1:0] CMP_GT   = 2'd2;
    localparam logic [1:0] CMP_LT   = 2'd3;

endpackage

// File: rtl/alu_seq_div.sv
// Iterative restoring divider: start loads operands, then one shift-subtract
// step per edge; done flags the final step with its result on the outputs.
module alu_seq_div #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // quo_q starts as the dividend and fills with quotient bits from the LSB
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = shifted[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign done      = (cnt_q == CNT_W'(1));
    assign quotient  = quo_step;
    assign remainder = rem_step;

endmodule

// File: rtl/alu_seq_top.sv
// Sequential 16-op ALU with valid/ready intake and one registered result bus.
// Macro ALU_DIV_REM_EN: divide results carry the remainder (or A on /0) in the high half.
//   state | meaning
//   IDLE  | ready; single-cycle ops and divide-by-zero complete here
//   DIV   | restoring divider busy for WIDTH edges; not ready
module alu_seq_top
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         ALU_FUN,
    output logic               OUT_VALID,
    output logic [2*WIDTH-1:0] ALU_OUT,
    output logic               Carry_OUT,
    output logic [3:0]         UNIT_FLAG,
    output logic               DIV_BY_ZERO
);

    localparam int W2 = 2 * WIDTH;

    alu_state_t     state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic [W2-1:0]  alu_out_q, alu_out_d;
    logic           carry_q, carry_d;
    logic [3:0]     unit_flag_q, unit_flag_d;
    logic           dbz_q, dbz_d;

    logic             accept;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_hi;

    logic [WIDTH:0]   sum;
    logic [W2-1:0]    prod;
    logic [W2-1:0]    su_res;
    logic             su_carry;
    logic [1:0]       unit_sel;
    logic [3:0]       su_flag;

    assign IN_READY = RST && (state_q == IDLE);
    assign accept   = IN_VALID && IN_READY;
    assign sum      = {1'b0, A} + {1'b0, B};
    assign prod     = W2'(A) * W2'(B);
    assign unit_sel = ALU_FUN[3:2];

    alu_seq_div #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
        .clk       (CLK),
        .rst_n     (RST),
        .start     (div_start),
        .dividend  (A),
        .divisor   (B),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

`ifdef ALU_DIV_REM_EN
    assign div_hi = div_rem;
`else
    logic unused_rem;
    assign unused_rem = ^div_rem;
    assign div_hi     = '0;
`endif

    always_comb begin
        su_flag             = '0;
        su_flag[UNIT_ARITH] = (unit_sel == 2'(UNIT_ARITH));
        su_flag[UNIT_LOGIC] = (unit_sel == 2'(UNIT_LOGIC));
        su_flag[UNIT_CMP]   = (unit_sel == 2'(UNIT_CMP));
        su_flag[UNIT_SHIFT] = (unit_sel == 2'(UNIT_SHIFT));
    end

    // Single-cycle result; for ALU_DIV this is only the divide-by-zero answer
    always_comb begin
        su_res   = '0;
        su_carry = 1'b0;
        case (ALU_FUN)
            ALU_ADD: begin
                su_res[WIDTH:0] = sum;
                su_carry        = sum[WIDTH];
            end
            ALU_SUB: begin
                su_res[WIDTH-1:0] = A - B;
                su_carry          = (A < B);
            end
            ALU_MUL: su_res = prod;
            ALU_DIV: begin
                su_res[WIDTH-1:0] = '1;
`ifdef ALU_DIV_REM_EN
                su_res[W2-1:WIDTH] = A;
`endif
            end
            ALU_AND:   su_res[WIDTH-1:0] = A & B;
            ALU_OR:    su_res[WIDTH-1:0] = A | B;
            ALU_NAND:  su_res[WIDTH-1:0] = ~(A & B);
            ALU_NOR:   su_res[WIDTH-1:0] = ~(A | B);
            ALU_NOP:   su_res[1:0] = CMP_NONE;
            ALU_EQ:    su_res[1:0] = (A == B) ? CMP_EQ : CMP_NONE;
            ALU_GT:    su_res[1:0] = (A > B)  ? CMP_GT : CMP_NONE;
            ALU_LT:    su_res[1:0] = (A < B)  ? CMP_LT : CMP_NONE;
            ALU_SHR_A: su_res[WIDTH-1:0] = A >> 1;
            ALU_SHL_A: su_res[WIDTH-1:0] = A << 1;
            ALU_SHR_B: su_res[WIDTH-1:0] = B >> 1;
            ALU_SHL_B: su_res[WIDTH-1:0] = B << 1;
            default:   su_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        alu_out_d   = alu_out_q;
        carry_d     = carry_q;
        unit_flag_d = unit_flag_q;
        dbz_d       = dbz_q;
        div_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((ALU_FUN == ALU_DIV) && (B != '0)) begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end else begin
                        out_valid_d = 1'b1;
                        alu_out_d   = su_res;
                        carry_d     = su_carry;
                        unit_flag_d = su_flag;
                        dbz_d       = (ALU_FUN == ALU_DIV);
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d                 = IDLE;
                    out_valid_d             = 1'b1;
                    alu_out_d               = {div_hi, div_quo};
                    carry_d                 = 1'b0;
                    unit_flag_d             = '0;
                    unit_flag_d[UNIT_ARITH] = 1'b1;
                    dbz_d                   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            carry_q     <= 1'b0;
            unit_flag_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            carry_q     <= carry_d;
            unit_flag_q <= unit_flag_d;
            dbz_q       <= dbz_d;
        end
    end

    assign OUT_VALID   = out_valid_q;
    assign ALU_OUT     = alu_out_q;
    assign Carry_OUT   = carry_q;
    assign UNIT_FLAG   = unit_flag_q;
    assign DIV_BY_ZERO = dbz_q;

endmodule
